// File: rtl/gearbox_pkg.sv
// gearbox_pkg
// Shared types and constants for the parametrised gearbox controller.
//   gear_state_e : top-level FSM state (neutral / drive / reverse)
//   SEG_N, SEG_R : 7-segment codes for 'n' and 'r' (bit order gfedcba)
//   SEG_DIGIT    : 7-segment codes for digits 0..9
//   seg_for()    : display code for a given state and forward gear
package gearbox_pkg;

  typedef enum logic [1:0] {
    ST_NEUTRAL = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_REVERSE = 2'd2
  } gear_state_e;

  localparam logic [6:0] SEG_N = 7'h54;
  localparam logic [6:0] SEG_R = 7'h50;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] seg_for(input gear_state_e st, input logic [3:0] g);
    logic [6:0] s;
    case (st)
      ST_NEUTRAL: s = SEG_N;
      ST_REVERSE: s = SEG_R;
      default:    s = (g <= 4'd9) ? SEG_DIGIT[g] : SEG_N;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/gearbox_debounce.sv
// gearbox_debounce
// Tick-sampled debouncer for one raw pad input, with rising-edge event.
//   clk, rst_n : system clock, asynchronous active-low reset
//   tick       : sample strobe (already qualified by the enable)
//   raw        : asynchronous raw input
//   level      : accepted (debounced) level
//   rise       : high for exactly one tick period after level goes 0 -> 1
module gearbox_debounce
  import gearbox_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);

  logic [1:0]    sync_q;
  logic          raw_s;
  logic [CW-1:0] cnt_q;

  // Two-flop synchronizer: pad inputs are asynchronous to clk.
  assign raw_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (tick) begin
        // rise is rewritten only on ticks so it stays valid for one whole
        // tick period and is seen by the FSM on the following tick.
        rise <= 1'b0;
        if (raw_s != level) begin
          if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
            level <= raw_s;
            cnt_q <= '0;
            rise  <= raw_s;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/gearbox_ctrl_param.sv
// gearbox_ctrl_param
// N-speed gearbox controller: debounced buttons, shift events, post-shift
// lockout, brake rules and a registered 7-segment gear display.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   ena            : freezes tick generation and all state when low
//   shift_up, shift_down, brake, reverse_req : raw pad inputs
//   gear           : current forward gear (0 in neutral/reverse)
//   neutral        : high in neutral
//   reverse_active : high in reverse
//   busy           : high while the post-shift lockout runs
//   seg            : active-high segments, gfedcba
// Optional build macro GEARBOX_BRAKE_DOWNSHIFT_EN: holding the brake in
// DRIVE(g>1) auto-downshifts one gear per lockout period down to DRIVE(1).
module gearbox_ctrl_param
  import gearbox_pkg::*;
#(
  parameter int NUM_GEARS      = 6,
  parameter int TICK_DIV       = 20000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int LOCKOUT_TICKS  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ena,
  input  logic                             shift_up,
  input  logic                             shift_down,
  input  logic                             brake,
  input  logic                             reverse_req,
  output logic [$clog2(NUM_GEARS+1)-1:0]   gear,
  output logic                             neutral,
  output logic                             reverse_active,
  output logic                             busy,
  output logic [6:0]                       seg
);

  localparam int GW = $clog2(NUM_GEARS + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam int LW = $clog2(LOCKOUT_TICKS + 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;

  logic up_lvl, dn_lvl, rev_lvl, brake_lvl;
  logic up_ev, dn_ev, rev_ev, brake_rise;
  logic unused_lvl;

  gear_state_e   state_q, state_d;
  logic [GW-1:0] gear_q, gear_d;
  logic [LW-1:0] lock_cnt;
  logic          lock_free;
  logic          up_ok, dn_ok, rev_ok;
  logic          chg;

  logic [6:0]    seg_d;
  logic          neutral_d, reverse_d;

  // ---- tick generation ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (ena) begin
      tick_cnt <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + TW'(1);
    end
  end

  assign tick = ena && (tick_cnt == TW'(TICK_DIV - 1));

  // ---- input debouncing ----
  gearbox_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_up (
    .clk(clk), .rst_n(rst_n), .tick(tick), .raw(shift_up),    .level(up_lvl),    .rise(up_ev));
  gearbox_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_dn (
    .clk(clk), .rst_n(rst_n), .tick(tick), .raw(shift_down),  .level(dn_lvl),    .rise(dn_ev));
  gearbox_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_rev (
    .clk(clk), .rst_n(rst_n), .tick(tick), .raw(reverse_req), .level(rev_lvl),   .rise(rev_ev));
  gearbox_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_brk (
    .clk(clk), .rst_n(rst_n), .tick(tick), .raw(brake),       .level(brake_lvl), .rise(brake_rise));

  // Buttons act on edges, the brake on its level; the remaining outputs
  // of the shared debouncer are deliberately left unused.
  assign unused_lvl = &{1'b0, up_lvl, dn_lvl, rev_lvl, brake_rise};

  // ---- event arbitration ----
  // The tick on which the counter hits zero already counts as free, so a
  // new change can follow exactly LOCKOUT_TICKS ticks after the last one.
  assign lock_free = !busy || (lock_cnt == LW'(1));
  assign up_ok     = up_ev  && !dn_ev && lock_free;
  assign dn_ok     = dn_ev  && !up_ev && lock_free;
  assign rev_ok    = rev_ev && lock_free;

  // ---- FSM: state register (outputs registered alongside) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_NEUTRAL;
      gear_q         <= '0;
      gear           <= '0;
      neutral        <= 1'b1;
      reverse_active <= 1'b0;
      seg            <= SEG_N;
    end else if (tick) begin
      state_q        <= state_d;
      gear_q         <= gear_d;
      gear           <= gear_d;
      neutral        <= neutral_d;
      reverse_active <= reverse_d;
      seg            <= seg_d;
    end
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    state_d = state_q;
    gear_d  = gear_q;
    if (tick) begin
      unique case (state_q)
        ST_NEUTRAL: begin
          if (up_ok) begin
            state_d = ST_DRIVE;
            gear_d  = GW'(1);
          end else if (rev_ok && brake_lvl) begin
            state_d = ST_REVERSE;
          end
        end
        ST_DRIVE: begin
`ifdef GEARBOX_BRAKE_DOWNSHIFT_EN
          // An explicit downshift in the same tick merges with the
          // brake-driven one: only a single gear is dropped.
          if (dn_ok || (brake_lvl && lock_free && (gear_q > GW'(1)))) begin
`else
          if (dn_ok) begin
`endif
            if (gear_q > GW'(1)) begin
              gear_d = gear_q - GW'(1);
            end else begin
              state_d = ST_NEUTRAL;
              gear_d  = '0;
            end
          end else if (up_ok && !brake_lvl && (gear_q < GW'(NUM_GEARS))) begin
            gear_d = gear_q + GW'(1);
          end
        end
        ST_REVERSE: begin
          if (up_ok || rev_ok) begin
            state_d = ST_NEUTRAL;
          end
        end
        default: begin
          state_d = ST_NEUTRAL;
          gear_d  = '0;
        end
      endcase
    end
  end

  // ---- FSM: output logic (decoded from the next state) ----
  always_comb begin
    neutral_d = (state_d == ST_NEUTRAL);
    reverse_d = (state_d == ST_REVERSE);
    seg_d     = seg_for(state_d, 4'(gear_d));
  end

  // ---- lockout ----
  assign chg = tick && ((state_d != state_q) || (gear_d != gear_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
      busy     <= 1'b0;
    end else if (tick) begin
      if (chg) begin
        lock_cnt <= LW'(LOCKOUT_TICKS);
        busy     <= 1'b1;
      end else if (busy) begin
        lock_cnt <= lock_cnt - LW'(1);
        if (lock_cnt == LW'(1)) begin
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gearbox_ctrl_param.sv
module tb_gearbox_ctrl_param;

  localparam int NG = 6;
  localparam int TD = 4;
  localparam int DB = 2;
  localparam int LK = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       shift_up = 1'b0;
  logic       shift_down = 1'b0;
  logic       brake = 1'b0;
  logic       reverse_req = 1'b0;
  logic [2:0] gear;
  logic       neutral;
  logic       reverse_active;
  logic       busy;
  logic [6:0] seg;

  always #5 clk = ~clk;

  gearbox_ctrl_param #(
    .NUM_GEARS(NG), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .LOCKOUT_TICKS(LK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .shift_up(shift_up), .shift_down(shift_down), .brake(brake), .reverse_req(reverse_req),
    .gear(gear), .neutral(neutral), .reverse_active(reverse_active), .busy(busy), .seg(seg)
  );

  typedef struct packed {
    logic [2:0] gear;
    logic       neu;
    logic       rev;
    logic [6:0] seg;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 = neutral, 1 = drive, 2 = reverse.
  int m_mode = 0;
  int m_gear = 0;
  bit m_brk  = 1'b0;

  // Monitor controls
  bit chk_busy = 1'b1;
  bit chk_iv   = 1'b0;
  int last_chg = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int mode, input int g);
    logic [6:0] s;
    if (mode == 0) s = 7'h54;
    else if (mode == 2) s = 7'h50;
    else begin
      case (g)
        1: s = 7'h06; 2: s = 7'h5B; 3: s = 7'h4F; 4: s = 7'h66; 5: s = 7'h6D;
        6: s = 7'h7D; 7: s = 7'h07; 8: s = 7'h7F; 9: s = 7'h6F;
        default: s = 7'h3F;
      endcase
    end
    return s;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.gear = (m_mode == 1) ? 3'(m_gear) : 3'd0;
    o.neu  = (m_mode == 0);
    o.rev  = (m_mode == 2);
    o.seg  = exp_seg(m_mode, m_gear);
    return o;
  endfunction

  task automatic check_state(input string tag);
    obs_t e;
    e = model_obs();
    check_eq({tag, "_gear"}, 32'(gear), 32'(e.gear));
    check_eq({tag, "_neutral"}, 32'(neutral), 32'(e.neu));
    check_eq({tag, "_reverse"}, 32'(reverse_active), 32'(e.rev));
    check_eq({tag, "_seg"}, 32'(seg), 32'(e.seg));
  endtask

  // Apply one accepted event set to the model; queue the expected display
  // if the state moves.
  task automatic model_event(input bit up, input bit dn, input bit rev);
    int om, og;
    om = m_mode;
    og = m_gear;
    if (!(up && dn)) begin
      case (m_mode)
        0: if (up) begin m_mode = 1; m_gear = 1; end
           else if (rev && m_brk) m_mode = 2;
        1: if (dn) begin
             if (m_gear > 1) m_gear--;
             else begin m_mode = 0; m_gear = 0; end
           end else if (up && !m_brk && m_gear < NG) m_gear++;
        default: if (up || rev) m_mode = 0;
      endcase
    end
    if (om != m_mode || og != m_gear) exp_q.push_back(model_obs());
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clean press: held 4 ticks, released 6 ticks (covers debounce + lockout).
  task automatic press(input bit up, input bit dn, input bit rev);
    model_event(up, dn, rev);
    shift_up = up; shift_down = dn; reverse_req = rev;
    wait_clk(4 * TD);
    shift_up = 1'b0; shift_down = 1'b0; reverse_req = 1'b0;
    wait_clk(6 * TD);
  endtask

  // Scoreboard monitor: every display change pops one expected entry.
  initial begin
    obs_t cur, prev, e;
    bit   prev_ok;
    int   cyc, busy_run;
    prev_ok  = 1'b0;
    cyc      = 0;
    busy_run = 0;
    prev     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {gear, neutral, reverse_active, seg};
      if (rst_n && prev_ok && cur != prev) begin
        check_eq("busy_on_change", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_change", 32'(cur), 32'(prev));
        end else begin
          e = exp_q.pop_front();
          check_eq("chg_gear", 32'(cur.gear), 32'(e.gear));
          check_eq("chg_neutral", 32'(cur.neu), 32'(e.neu));
          check_eq("chg_reverse", 32'(cur.rev), 32'(e.rev));
          check_eq("chg_seg", 32'(cur.seg), 32'(e.seg));
        end
        if (chk_iv && last_chg >= 0) check_eq("auto_interval", 32'(cyc - last_chg), 32'(LK * TD));
        last_chg = cyc;
      end
      prev    = cur;
      prev_ok = rst_n;
      if (busy) begin
        busy_run++;
      end else begin
        if (busy_run != 0 && chk_busy && rst_n) check_eq("busy_len", 32'(busy_run), 32'(LK * TD));
        busy_run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int i;
    rst_n = 1'b0;
    wait_clk(3);
    check_state("reset");
    check_eq("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_clk(2);

    // One-tick glitch must not be accepted
    shift_up = 1'b1;
    wait_clk(TD);
    shift_up = 1'b0;
    wait_clk(8 * TD);
    check_state("glitch");

    // Three upshifts
    repeat (3) press(1, 0, 0);
    check_state("up3");
    check_eq("up3_seg_code", 32'(seg), 32'h4F);

    // Saturate at top gear
    repeat (3) press(1, 0, 0);
    press(1, 0, 0);
    check_state("sat_top");

    // All the way down to neutral, then a down in neutral is ignored
    repeat (6) press(0, 1, 0);
    check_state("down_to_n");
    press(0, 1, 0);
    check_state("dn_in_n");

    // Reverse needs the brake
    press(0, 0, 1);
    check_state("rev_no_brake");
    brake = 1'b1; m_brk = 1'b1;
    wait_clk(4 * TD);
    press(0, 0, 1);
    check_state("rev_entry");
    check_eq("rev_seg_code", 32'(seg), 32'h50);
    press(0, 1, 0);
    check_state("dn_in_rev");
    press(1, 0, 0);
    check_state("rev_exit");
    brake = 1'b0; m_brk = 1'b0;
    wait_clk(4 * TD);

    // Second event one tick into the lockout is dropped
    model_event(1, 0, 0);
    shift_up = 1'b1;
    wait_clk(TD);
    shift_down = 1'b1;
    wait_clk(4 * TD);
    shift_up = 1'b0; shift_down = 1'b0;
    wait_clk(6 * TD);
    check_state("lockout_drop");

    // Simultaneous up + down cancel
    press(1, 1, 0);
    check_state("up_dn_same");

    repeat (3) press(1, 0, 0);
    check_state("drive4");

`ifdef GEARBOX_BRAKE_DOWNSHIFT_EN
    chk_busy = 1'b0;
    last_chg = -1;
    chk_iv   = 1'b1;
    for (int g = 3; g >= 1; g--) begin
      m_gear = g;
      exp_q.push_back(model_obs());
    end
    brake = 1'b1;
    wait_clk(20 * TD);
    check_state("brake_auto_ds");
    chk_iv = 1'b0;
    brake  = 1'b0;
    wait_clk(6 * TD);
    chk_busy = 1'b1;
    repeat (3) press(1, 0, 0);
    check_state("back_to_4");
`else
    brake = 1'b1; m_brk = 1'b1;
    wait_clk(4 * TD);
    press(1, 0, 0);
    check_state("brake_inhibit");
    wait_clk(10 * TD);
    check_state("brake_hold");
    brake = 1'b0; m_brk = 1'b0;
    wait_clk(4 * TD);
`endif

    // Reset in the middle of a lockout in DRIVE(4)
    press(0, 1, 0);
    model_event(1, 0, 0);
    shift_up = 1'b1;
    i = 0;
    while (i < 20 * TD && gear != 3'd4) begin
      wait_clk(1);
      i++;
    end
    check_eq("reach_drive4", 32'(gear), 32'd4);
    chk_busy = 1'b0;
    wait_clk(TD);
    check_eq("busy_mid_lockout", 32'(busy), 32'd1);
    rst_n = 1'b0;
    m_mode = 0; m_gear = 0;
    #1;
    check_state("async_reset");
    check_eq("async_reset_busy", 32'(busy), 32'd0);
    shift_up = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(10 * TD);
    check_state("post_reset");
    chk_busy = 1'b1;

    // ena low freezes everything
    ena = 1'b0;
    shift_up = 1'b1;
    wait_clk(8 * TD);
    shift_up = 1'b0;
    wait_clk(2);
    ena = 1'b1;
    wait_clk(6 * TD);
    check_state("ena_freeze");

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
